// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg: mode and state encodings shared by the universal shift register
package univ_shift_pkg;
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_e;
  function automatic logic is_shift(input logic [2:0] m);
    return m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR};
  endfunction
endpackage

// File: rtl/usr_shift_step.sv
// usr_shift_step: one combinational shift/rotate step (i_q,i_mode,i_sin -> o_q next value, o_out exiting bit)
module usr_shift_step import univ_shift_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  mode_e            i_mode,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_out
);
  always_comb begin
    o_q   = i_mode == MODE_SHL ? {i_q[WIDTH-2:0], i_sin} :
            i_mode == MODE_SHR ? {i_sin, i_q[WIDTH-1:1]} :
            i_mode == MODE_ROL ? {i_q[WIDTH-2:0], i_q[WIDTH-1]} :
            i_mode == MODE_ROR ? {i_q[0], i_q[WIDTH-1:1]} :
            i_mode == MODE_ASR ? {i_q[WIDTH-1], i_q[WIDTH-1:1]} : i_q;
    o_out = (i_mode == MODE_SHL || i_mode == MODE_ROL) ? i_q[WIDTH-1] : i_q[0];
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: WIDTH-bit universal shift register with load, shift-by-N sequencer and BUSY/DONE handshake
module univ_shift_reg import univ_shift_pkg::*; #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CNT_W     = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  input  logic [CNT_W-1:0] AMT,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);
  state_e           r_state, w_state_nxt;
  mode_e            r_mode;
  logic [CNT_W-1:0] r_cnt, w_amt;
  logic [WIDTH-1:0] r_q, w_step_q;
  logic             r_sout, r_done, w_step_out, w_go, w_done_nxt, w_last;
  usr_shift_step #(.WIDTH(WIDTH)) u_step (
    .i_q   (r_q),
    .i_mode(r_mode),
    .i_sin (SIN),
    .o_q   (w_step_q),
    .o_out (w_step_out)
  );
  always_comb begin
    w_go        = START && is_shift(MODE) && AMT != '0;
    w_amt       = AMT > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : AMT;
    w_last      = r_cnt == CNT_W'(1);
    w_state_nxt = r_state == ST_IDLE ? (w_go ? ST_SHIFT : ST_IDLE) : (w_last ? ST_IDLE : ST_SHIFT);
    w_done_nxt  = r_state == ST_IDLE ? START && !w_go : w_last;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_q    <= RESET_VAL;
      r_sout <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_mode <= MODE_HOLD;
    end else begin
      r_done <= w_done_nxt;
      if (r_state == ST_IDLE) begin
        if (START && MODE == MODE_LOAD) r_q <= D;
        if (w_go) begin
          r_mode <= mode_e'(MODE);
          r_cnt  <= w_amt;
        end
      end else begin
        r_q    <= w_step_q;
        r_sout <= w_step_out;
        r_cnt  <= r_cnt - CNT_W'(1);
      end
    end
  end
  assign Q    = r_q;
  assign SOUT = r_sout;
  assign BUSY = r_state == ST_SHIFT;
  assign DONE = r_done;
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register built from the team's D flip-flop primitive style, generalised from a single-bit DFF to a WIDTH-bit register. Supports parallel load, logical/arithmetic shifts and rotates, with a multi-cycle "shift by N" sequencer and a BUSY/DONE handshake. Serves as a generic datapath register and serialiser for the RTL library.

Parameters:
WIDTH, 8, register width in bits (>= 2)
RESET_VAL, {WIDTH{1'b0}}, value of Q after reset
CNT_W (localparam), $clog2(WIDTH)+1, width of AMT and the internal remaining-shift counter

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous reset, active-low
START  in  1  request an operation; sampled only in IDLE
MODE  in  3  operation select, latched at START
D  in  WIDTH  parallel load data
SIN  in  1  serial input for SHL/SHR, sampled live at each shift edge
AMT  in  CNT_W  number of shifts, latched at START
Q  out  WIDTH  register contents
SOUT  out  1  last bit shifted/rotated out; holds between shifts
BUSY  out  1  high while in SHIFT state
DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (RST=0, async): Q=RESET_VAL, SOUT=0, BUSY=0, DONE=0, state=IDLE, counter=0. Reset mid-operation aborts the operation; no DONE is issued.
- MODE encoding: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 reserved (treated as HOLD).
- States: IDLE, SHIFT. BUSY = (state==SHIFT), decoded from the state register.
- IDLE, START=1, MODE=LOAD: Q<=D on that edge; DONE=1 for the following cycle; remain IDLE.
- IDLE, START=1, MODE=HOLD/reserved, or shift mode with AMT=0: Q unchanged; DONE=1 for the following cycle; remain IDLE.
- IDLE, START=1, shift mode, AMT>0: latch MODE; counter<=min(AMT,WIDTH) (AMT>WIDTH clamps to WIDTH); go to SHIFT. Q does not change on the START edge.
- SHIFT: each edge performs one step, decrements the counter, and updates SOUT with the exiting bit. When the counter is 1 at the edge, go to IDLE and DONE=1 for the next cycle. Latency: N shifts occupy edges 1..N after START; DONE is high in the cycle after edge N; BUSY is high for exactly N cycles.
- Step rules: SHL Q<={Q[W-2:0],SIN}, out=Q[W-1]. SHR Q<={SIN,Q[W-1:1]}, out=Q[0]. ROL Q<={Q[W-2:0],Q[W-1]}, out=Q[W-1]. ROR Q<={Q[0],Q[W-1:1]}, out=Q[0]. ASR Q<={Q[W-1],Q[W-1:1]}, out=Q[0], SIN ignored.
- START, MODE, AMT and D are ignored while BUSY. START in the DONE cycle is accepted, since state is IDLE. DONE never coincides with BUSY.
- SOUT changes only on shift edges. LOAD and HOLD leave SOUT unchanged.

Decomposition:
- Package univ_shift_pkg: MODE encoding constants (MODE_HOLD..MODE_ASR), state encoding (ST_IDLE, ST_SHIFT).
- Sub-module usr_shift_step: combinational one-step shifter. Inputs are Q, mode and SIN; outputs are next Q and the exiting bit. It is instantiated once in univ_shift_reg.

Test Plan:
1. WIDTH=8. Assert RST=0 mid-SHIFT between clock edges -> Q=00, SOUT=0, BUSY=0, DONE=0 immediately (async); no DONE after release.
2. LOAD D=8'hA5, START for one cycle -> Q=A5 after edge; DONE high for one cycle; BUSY never high.
3. From Q=A5: SHL, AMT=3, SIN=1 -> BUSY for 3 cycles; Q steps 4B, 97, 2F; SOUT steps 1, 0, 1; DONE pulses once after the third edge.
4. From Q=3C: ROR, AMT=12 (clamped to 8) -> BUSY for exactly 8 cycles; final Q=3C; SOUT=0.
5. From Q=90: ASR, AMT=2, SIN=1 -> Q=C8 then E4; SOUT=0; SIN has no effect.
6. START with SHL, AMT=0 -> DONE next cycle, Q and SOUT unchanged. START pulsed while BUSY -> ignored; the operation in progress completes unaltered.
